hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage pipeline.
//  - Generates forwarding selects for NUM_SRC operands.
//  - Inserts load-use bubbles using a counter-driven FSM.
//  - Freezes the pipeline while a memory op in EX/MEM waits on mem_ready, with a watchdog timeout.
//  Sits beside the ID/EX/MEM pipeline registers; drives PC, IF/ID, ID/EX and EX/MEM enables and operand muxes.
// PARAMETERS
//  AW            3    register address width
//  NUM_SRC       2    source operands per instruction (1..4)
//  LU_STALL_CYC  1    bubbles inserted per load-use hazard (1..7)
//  MAX_WAIT      255  mem_ready wait cycles before mem_timeout is set
//  CNT_W         16   perf counter width (HAZ_PERF_CNT_EN only)
// PORTS
//  clk             in   1           clock
//  rst_n           in   1           async active-low reset
//  if_id_src       in   NUM_SRC*AW  IF/ID source regs; operand i at [i*AW+:AW]
//  if_id_src_vld   in   NUM_SRC     operand i actually read
//  id_ex_src       in   NUM_SRC*AW  ID/EX source regs
//  id_ex_rd        in   AW          ID/EX destination
//  id_ex_memread   in   1           ID/EX holds a load
//  ex_mem_rd       in   AW          EX/MEM destination
//  ex_mem_regwrite in   1           EX/MEM writes rd
//  ex_mem_memop    in   1           EX/MEM holds a load/store
//  mem_ready       in   1           data memory completes this cycle
//  mem_wb_rd       in   AW          MEM/WB destination
//  mem_wb_regwrite in   1           MEM/WB writes rd
//  fwd_sel         out  2*NUM_SRC   per operand: 00 RF, 10 EX/MEM, 01 MEM/WB
//  pc_en           out  1           PC update enable
//  if_id_en        out  1           IF/ID load enable
//  id_ex_en        out  1           ID/EX load enable
//  id_ex_flush     out  1           load bubble into ID/EX
//  ex_mem_en       out  1           EX/MEM load enable
//  mem_timeout     out  1           sticky watchdog error
// BEHAVIOUR
//  Reset: one clock, async active-low reset. While rst_n=0:
//   - all enables=0, id_ex_flush=0, fwd_sel=0, mem_timeout=0.
//   - FSM=RUN, all counters cleared.
//  Forwarding (combinational, every operand i):
//   - 10 if ex_mem_regwrite, ex_mem_rd!=0 and ex_mem_rd==src_i.
//   - Else 01 if mem_wb_regwrite, mem_wb_rd!=0 and mem_wb_rd==src_i.
//   - Else 00. EX/MEM wins over MEM/WB. 11 is never driven.
//  lu_hit = id_ex_memread && id_ex_rd!=0 && any(if_id_src_vld[i] && if_id_src_i==id_ex_rd).
//  mw_hit = ex_mem_memop && !mem_ready.
//  FSM states RUN, BUBBLE, MEM_WAIT. bub_cnt is 3b; wait_cnt is clog2(MAX_WAIT+1)b.
//   - RUN: all enables=1, flush=0.
//     - mw_hit -> MEM_WAIT.
//     - Else lu_hit -> pc_en=if_id_en=0, flush=1 in the same cycle; bub_cnt=LU_STALL_CYC-1;
//       go to BUBBLE if bub_cnt!=0, else stay in RUN.
//   - BUBBLE: pc_en=if_id_en=0, flush=1, bub_cnt decrements; exit to RUN at 0.
//     - mw_hit takes priority: go to MEM_WAIT with bub_cnt held.
//   - MEM_WAIT: every enable=0 and flush=0 (full freeze); wait_cnt increments.
//     - Return to the saved state (RUN or BUBBLE) in the cycle after mem_ready=1.
//     - wait_cnt clears on exit.
//  Priority: mw_hit > lu_hit. A load-use seen during a freeze is re-evaluated after exit (ID/EX is frozen).
//  Timeout: wait_cnt==MAX_WAIT sets mem_timeout (sticky until reset). wait_cnt saturates; the freeze holds.
//  Reset asserted mid-stall: immediate return to RUN; the bubble in progress is abandoned.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - Adds outputs stall_cycles[CNT_W-1:0] and fwd_events[CNT_W-1:0].
//   - Both are saturating and reset to 0.
//   - stall_cycles counts cycles with pc_en=0 after reset.
//   - fwd_events counts cycles in which any fwd_sel!=00.
//  Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  - ex_mem_rd=3, regwrite=1, id_ex src0=3, src1=3; mem_wb_rd=3 -> fwd_sel=4'b1010 (EX/MEM wins).
//  - ex_mem_rd=0, regwrite=1, src0=0 -> fwd_sel[1:0]=00; mem_wb_rd=5 with src1=5 -> fwd_sel[3:2]=01.
//  - LU_STALL_CYC=2: load rd=4, if_id src0=4 vld -> two cycles pc_en=0 and flush=1, then RUN.
//    - Same case with vld=0 -> no stall.
//  - ex_mem_memop=1, mem_ready=0 for 5 cycles -> all enables 0 for 5 cycles.
//    - Resume in the cycle after mem_ready=1; mem_timeout stays 0.
//  - MAX_WAIT=8, mem_ready held 0 -> mem_timeout=1 after 8 wait cycles.
//    - It stays 1 after mem_ready=1 until rst_n=0.
//  - lu_hit and mw_hit together, then rst_n pulsed mid-BUBBLE -> MEM_WAIT first.
//    - After the reset pulse: enables=0 during reset, all 1 in the first cycle after release.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard and forwarding controller for a 5-stage in-order pipeline. Sits
// beside the ID/EX, EX/MEM and MEM/WB pipeline registers and produces:
//   * operand forwarding selects for the EX stage (EX/MEM has priority over
//     MEM/WB, register 0 is never forwarded),
//   * load-use bubbles (LU_STALL_CYC bubbles per hazard, counter driven),
//   * a full pipeline freeze while a memory op in EX/MEM waits on mem_ready,
//     guarded by a sticky watchdog (mem_timeout).
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   When defined, adds saturating performance counters stall_cycles and
//   fwd_events. When undefined, those ports and counters are absent.
//
// Parameters
//   AW            register address width
//   NUM_SRC       source operands per instruction (1..4)
//   LU_STALL_CYC  bubbles inserted per load-use hazard (1..7)
//   MAX_WAIT      mem_ready wait cycles before mem_timeout is set (>=1)
//   CNT_W         perf counter width (HAZ_PERF_CNT_EN only)
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   if_id_src/_vld    IF/ID source registers and "operand really read" flags
//   id_ex_src         ID/EX source registers (forwarding compare)
//   id_ex_rd/_memread ID/EX destination and "is a load"
//   ex_mem_rd/_regwrite/_memop, mem_ready   EX/MEM state and memory handshake
//   mem_wb_rd/_regwrite                     MEM/WB state
//   fwd_sel           per operand i at [2i+:2]: 00 RF, 10 EX/MEM, 01 MEM/WB
//   pc_en, if_id_en, id_ex_en, ex_mem_en    pipeline register enables
//   id_ex_flush       load a bubble into ID/EX
//   mem_timeout       sticky watchdog error
//   stall_cycles, fwd_events                perf counters (HAZ_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int AW           = 3,
  parameter int NUM_SRC      = 2,
  parameter int LU_STALL_CYC = 1,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  if_id_src,
  input  logic [NUM_SRC-1:0]     if_id_src_vld,
  input  logic [NUM_SRC*AW-1:0]  id_ex_src,
  input  logic [AW-1:0]          id_ex_rd,
  input  logic                   id_ex_memread,
  input  logic [AW-1:0]          ex_mem_rd,
  input  logic                   ex_mem_regwrite,
  input  logic                   ex_mem_memop,
  input  logic                   mem_ready,
  input  logic [AW-1:0]          mem_wb_rd,
  input  logic                   mem_wb_regwrite,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       fwd_events
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (NUM_SRC < 1 || NUM_SRC > 4 || LU_STALL_CYC < 1 || LU_STALL_CYC > 7 ||
      MAX_WAIT < 1 || CNT_W < 1 || AW < 1) begin : g_bad_param
    $error("hazard_fwd_ctrl: parameter out of range");
  end

  localparam int             WAIT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [2:0]     LU_BUB_INIT = 3'(LU_STALL_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Forwarding selects
  // ---------------------------------------------------------------------------
  logic [2*NUM_SRC-1:0] fwd_raw;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    fwd_raw = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_mem_regwrite && (ex_mem_rd != '0) &&
          (ex_mem_rd == id_ex_src[i*AW +: AW])) begin
        fwd_raw[2*i +: 2] = 2'b10;
      end else if (mem_wb_regwrite && (mem_wb_rd != '0) &&
                   (mem_wb_rd == id_ex_src[i*AW +: AW])) begin
        fwd_raw[2*i +: 2] = 2'b01;
      end
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after
  // the first clock edge.
  assign fwd_sel = rst_n ? fwd_raw : '0;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic lu_match;
  logic lu_hit;
  logic mw_hit;

  always_comb begin
    lu_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (if_id_src_vld[i] && (if_id_src[i*AW +: AW] == id_ex_rd)) begin
        lu_match = 1'b1;
      end
    end
  end

  assign lu_hit = id_ex_memread && (id_ex_rd != '0) && lu_match;
  assign mw_hit = ex_mem_memop && !mem_ready;

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  state_t              state_q, state_nxt;
  state_t              ret_q, ret_nxt;     // state to resume after MEM_WAIT
  logic [2:0]          bub_q, bub_nxt;
  logic [WAIT_W-1:0]   wait_q, wait_nxt;
  logic                timeout_q;

  logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, flush_c;

  always_comb begin
    state_nxt   = state_q;
    ret_nxt     = ret_q;
    bub_nxt     = bub_q;
    wait_nxt    = wait_q;
    pc_en_c     = 1'b1;
    if_id_en_c  = 1'b1;
    id_ex_en_c  = 1'b1;
    ex_mem_en_c = 1'b1;
    flush_c     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mw_hit) begin
          state_nxt = ST_MEM_WAIT;
          ret_nxt   = ST_RUN;
        end else if (lu_hit) begin
          // The first bubble is issued in the detecting cycle itself.
          pc_en_c    = 1'b0;
          if_id_en_c = 1'b0;
          flush_c    = 1'b1;
          bub_nxt    = LU_BUB_INIT;
          state_nxt  = (LU_BUB_INIT != 3'd0) ? ST_BUBBLE : ST_RUN;
        end
      end

      ST_BUBBLE: begin
        pc_en_c    = 1'b0;
        if_id_en_c = 1'b0;
        flush_c    = 1'b1;
        if (mw_hit) begin
          // Remaining bubble count is held across the freeze.
          state_nxt = ST_MEM_WAIT;
          ret_nxt   = ST_BUBBLE;
        end else if (bub_q <= 3'd1) begin
          bub_nxt   = 3'd0;
          state_nxt = ST_RUN;
        end else begin
          bub_nxt   = bub_q - 3'd1;
        end
      end

      ST_MEM_WAIT: begin
        pc_en_c     = 1'b0;
        if_id_en_c  = 1'b0;
        id_ex_en_c  = 1'b0;
        ex_mem_en_c = 1'b0;
        // Leave as soon as the memory op is no longer waiting; this covers
        // mem_ready and also never traps the FSM if memop drops.
        if (!mw_hit) begin
          state_nxt = ret_q;
          wait_nxt  = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_nxt  = wait_q + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_RUN;
        ret_nxt   = ST_RUN;
        bub_nxt   = 3'd0;
        wait_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      bub_q     <= 3'd0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ret_q   <= ret_nxt;
      bub_q   <= bub_nxt;
      wait_q  <= wait_nxt;
      // Sticky: set on the edge the wait counter reaches MAX_WAIT.
      if ((state_q == ST_MEM_WAIT) && (wait_nxt == WAIT_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign pc_en       = rst_n & pc_en_c;
  assign if_id_en    = rst_n & if_id_en_c;
  assign id_ex_en    = rst_n & id_ex_en_c;
  assign ex_mem_en   = rst_n & ex_mem_en_c;
  assign id_ex_flush = rst_n & flush_c;
  assign mem_timeout = timeout_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if ((fwd_raw != '0) && (fwd_events != '1)) begin
        fwd_events <= fwd_events + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Directed self-checking bench for hazard_fwd_ctrl (AW=3, NUM_SRC=2,
// LU_STALL_CYC=2, MAX_WAIT=8). Inputs change on the falling edge and outputs
// are sampled 1 ns later, away from the rising (active) edge.
// ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_flush}
//   RUN 5'b11110, bubble 5'b00111, freeze 5'b00000.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int AW      = 3;
  localparam int NUM_SRC = 2;

  localparam logic [4:0] CTL_RUN    = 5'b11110;
  localparam logic [4:0] CTL_BUB    = 5'b00111;
  localparam logic [4:0] CTL_FREEZE = 5'b00000;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_SRC*AW-1:0] if_id_src;
  logic [NUM_SRC-1:0]    if_id_src_vld;
  logic [NUM_SRC*AW-1:0] id_ex_src;
  logic [AW-1:0]         id_ex_rd;
  logic                  id_ex_memread;
  logic [AW-1:0]         ex_mem_rd;
  logic                  ex_mem_regwrite;
  logic                  ex_mem_memop;
  logic                  mem_ready;
  logic [AW-1:0]         mem_wb_rd;
  logic                  mem_wb_regwrite;
  logic [2*NUM_SRC-1:0]  fwd_sel;
  logic                  pc_en, if_id_en, id_ex_en, id_ex_flush, ex_mem_en;
  logic                  mem_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0]           stall_cycles;
  logic [15:0]           fwd_events;
`endif

  logic [4:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_flush};

  int n_tests = 0;
  int n_fail  = 0;

  hazard_fwd_ctrl #(
    .AW(AW), .NUM_SRC(NUM_SRC), .LU_STALL_CYC(2), .MAX_WAIT(8), .CNT_W(16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_id_src       (if_id_src),
    .if_id_src_vld   (if_id_src_vld),
    .id_ex_src       (id_ex_src),
    .id_ex_rd        (id_ex_rd),
    .id_ex_memread   (id_ex_memread),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_memop    (ex_mem_memop),
    .mem_ready       (mem_ready),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .fwd_sel         (fwd_sel),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_timeout     (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .fwd_events      (fwd_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    if_id_src       = '0;
    if_id_src_vld   = '0;
    id_ex_src       = '0;
    id_ex_rd        = '0;
    id_ex_memread   = 1'b0;
    ex_mem_rd       = '0;
    ex_mem_regwrite = 1'b0;
    ex_mem_memop    = 1'b0;
    mem_ready       = 1'b0;
    mem_wb_rd       = '0;
    mem_wb_regwrite = 1'b0;
  endtask

  // Load in ID/EX writing r4; IF/ID operand 0 reads r4.
  task automatic set_load_use();
    id_ex_memread = 1'b1;
    id_ex_rd      = 3'd4;
    if_id_src     = {3'd0, 3'd4};
    if_id_src_vld = 2'b01;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    // Active hazards and forwarding matches must all be masked by reset.
    ex_mem_regwrite = 1'b1; ex_mem_rd = 3'd3; id_ex_src = {3'd3, 3'd3};
    set_load_use();
    #1;
    n_tests++;
    if (ctl !== CTL_FREEZE) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_FREEZE);
    end
    n_tests++;
    if (fwd_sel !== 4'b0000) begin
      n_fail++; $display("FAIL reset_fwd: got %b expected 0000", fwd_sel);
    end
    n_tests++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    n_tests++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", ctl, CTL_RUN);
    end
  endtask

  task automatic test_forwarding();
    logic [AW-1:0]        v_exr [5];
    logic                 v_exw [5];
    logic [AW-1:0]        v_wbr [5];
    logic                 v_wbw [5];
    logic [NUM_SRC*AW-1:0] v_src [5];
    logic [3:0]           v_exp [5];
    // EX/MEM wins over MEM/WB on both operands
    v_exr[0] = 3'd3; v_exw[0] = 1'b1; v_wbr[0] = 3'd3; v_wbw[0] = 1'b1;
    v_src[0] = {3'd3, 3'd3}; v_exp[0] = 4'b1010;
    // r0 never forwarded; op1 from MEM/WB
    v_exr[1] = 3'd0; v_exw[1] = 1'b1; v_wbr[1] = 3'd5; v_wbw[1] = 1'b1;
    v_src[1] = {3'd5, 3'd0}; v_exp[1] = 4'b0100;
    // EX/MEM match without regwrite falls through to MEM/WB
    v_exr[2] = 3'd2; v_exw[2] = 1'b0; v_wbr[2] = 3'd2; v_wbw[2] = 1'b1;
    v_src[2] = {3'd2, 3'd2}; v_exp[2] = 4'b0101;
    // op0 from EX/MEM, op1 from MEM/WB
    v_exr[3] = 3'd6; v_exw[3] = 1'b1; v_wbr[3] = 3'd1; v_wbw[3] = 1'b1;
    v_src[3] = {3'd1, 3'd6}; v_exp[3] = 4'b0110;
    // matches but no writers -> RF
    v_exr[4] = 3'd7; v_exw[4] = 1'b0; v_wbr[4] = 3'd7; v_wbw[4] = 1'b0;
    v_src[4] = {3'd7, 3'd7}; v_exp[4] = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ex_mem_rd = v_exr[k]; ex_mem_regwrite = v_exw[k];
      mem_wb_rd = v_wbr[k]; mem_wb_regwrite = v_wbw[k];
      id_ex_src = v_src[k];
      #1;
      n_tests++;
      if (fwd_sel !== v_exp[k]) begin
        n_fail++;
        $display("FAIL fwd_vec%0d: got %b expected %b", k, fwd_sel, v_exp[k]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic [4:0] exp_ctl;
    // Hazard: two bubble cycles, then RUN.
    set_load_use();
    #1;
    n_tests++;
    if (ctl !== CTL_BUB) begin
      n_fail++; $display("FAIL lu_bubble0: got %b expected %b", ctl, CTL_BUB);
    end
    @(negedge clk);
    id_ex_memread = 1'b0;   // ID/EX now holds the inserted bubble
    #1;
    n_tests++;
    if (ctl !== CTL_BUB) begin
      n_fail++; $display("FAIL lu_bubble1: got %b expected %b", ctl, CTL_BUB);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL lu_resume: got %b expected %b", ctl, CTL_RUN);
    end
    // Same registers, operand not read -> no stall for two cycles.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_load_use();
      if_id_src_vld = 2'b00;
      #1;
      exp_ctl = CTL_RUN;
      n_tests++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL lu_novld%0d: got %b expected %b", k, ctl, exp_ctl);
      end
    end
    // Load to r0 never stalls.
    @(negedge clk);
    idle_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 3'd0; if_id_src = {3'd0, 3'd0};
    if_id_src_vld = 2'b11;
    #1;
    n_tests++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL lu_r0: got %b expected %b", ctl, CTL_RUN);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    logic [4:0] exp_ctl;
    // mem_ready low for cycles 0..4, high in cycle 5, op gone in cycle 6.
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      ex_mem_memop = (k < 6);
      mem_ready    = (k == 5);
      #1;
      exp_ctl = (k == 0 || k == 6) ? CTL_RUN : CTL_FREEZE;
      n_tests++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL mw_cyc%0d: got %b expected %b", k, ctl, exp_ctl);
      end
    end
    n_tests++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mw_no_timeout: got %b expected 0", mem_timeout);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_bubble_mem_wait();
    logic [4:0] exp_ctl [6];
    exp_ctl[0] = CTL_BUB;    // RUN detects load-use
    exp_ctl[1] = CTL_BUB;    // BUBBLE, mem wait starts -> MEM_WAIT
    exp_ctl[2] = CTL_FREEZE; // MEM_WAIT
    exp_ctl[3] = CTL_FREEZE; // MEM_WAIT, mem_ready=1
    exp_ctl[4] = CTL_BUB;    // back to BUBBLE with held count
    exp_ctl[5] = CTL_RUN;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      idle_inputs();
      if (k == 0) set_load_use();
      ex_mem_memop = (k >= 1 && k <= 3);
      mem_ready    = (k == 3);
      #1;
      n_tests++;
      if (ctl !== exp_ctl[k]) begin
        n_fail++;
        $display("FAIL bub_mw_cyc%0d: got %b expected %b", k, ctl, exp_ctl[k]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic exp_to;
    ex_mem_memop = 1'b1; mem_ready = 1'b0;
    #1;
    n_tests++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL to_enter: got %b expected %b", ctl, CTL_RUN);
    end
    for (int w = 1; w <= 10; w++) begin
      @(negedge clk);
      #1;
      exp_to = (w >= 9);  // set on the edge ending the 8th wait cycle
      n_tests++;
      if (mem_timeout !== exp_to) begin
        n_fail++; $display("FAIL to_wait%0d: got %b expected %b", w, mem_timeout, exp_to);
      end
      n_tests++;
      if (ctl !== CTL_FREEZE) begin
        n_fail++; $display("FAIL to_freeze%0d: got %b expected %b", w, ctl, CTL_FREEZE);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL to_resume: got %b expected %b", ctl, CTL_RUN);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL to_sticky: got %b expected 1", mem_timeout);
    end
  endtask

  task automatic test_hit_combo_reset();
    logic [4:0] exp_ctl [5];
    exp_ctl[0] = CTL_RUN;    // both hits: mem wait wins, no flush
    exp_ctl[1] = CTL_FREEZE;
    exp_ctl[2] = CTL_FREEZE; // mem_ready=1
    exp_ctl[3] = CTL_BUB;    // load-use re-evaluated after the freeze
    exp_ctl[4] = CTL_BUB;    // BUBBLE
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_inputs();
      set_load_use();
      ex_mem_memop = (k <= 2);
      mem_ready    = (k == 2);
      if (k == 4) begin
        ex_mem_regwrite = 1'b1; ex_mem_rd = 3'd4; id_ex_src = {3'd0, 3'd4};
      end
      #1;
      n_tests++;
      if (ctl !== exp_ctl[k]) begin
        n_fail++;
        $display("FAIL combo_cyc%0d: got %b expected %b", k, ctl, exp_ctl[k]);
      end
    end
    n_tests++;
    if (fwd_sel !== 4'b0010) begin
      n_fail++; $display("FAIL combo_fwd: got %b expected 0010", fwd_sel);
    end
    // Pulse reset mid-BUBBLE, held across one rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ctl !== CTL_FREEZE) begin
      n_fail++; $display("FAIL combo_rst_ctl: got %b expected %b", ctl, CTL_FREEZE);
    end
    n_tests++;
    if (fwd_sel !== 4'b0000) begin
      n_fail++; $display("FAIL combo_rst_fwd: got %b expected 0000", fwd_sel);
    end
    n_tests++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL combo_rst_timeout: got %b expected 0", mem_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_tests++;
      if (ctl !== CTL_RUN) begin
        n_fail++; $display("FAIL combo_release%0d: got %b expected %b", k, ctl, CTL_RUN);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_bubble_mem_wait();
    test_timeout();
    test_hit_combo_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
